// File: rtl/hs_ser_pkg.sv
// -----------------------------------------------------------------------------
// hs_ser_pkg
// Shared types and helpers for the HS transmit serializer.
//   ser_state_t  : serializer FSM state (IDLE / SYNC / SHIFT)
//   SYNC_DEFAULT : default SoT sync pattern
//   calc_beats   : beats per input word (WIDTH / OUT_W)
//   calc_cnt_w   : beat counter width, $clog2(BEATS) with a floor of 1
// -----------------------------------------------------------------------------
package hs_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_SHIFT = 2'd2
  } ser_state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hB8;

  function automatic int calc_beats(input int width, input int out_w);
    return width / out_w;
  endfunction

  function automatic int calc_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/hs_ser_hold_buf.sv
// -----------------------------------------------------------------------------
// hs_ser_hold_buf
// One-entry holding register (data + last flag) in front of the shift register.
// Ports:
//   clk      in   clock (TxDDRClk)
//   rst_n    in   synchronous active-low reset
//   in_data  in   word offered by the upstream byte path
//   in_valid in   in_data valid
//   in_last  in   final word of a burst
//   drain    in   shift stage takes the held word on this edge
//   in_ready out  entry free and not in reset
//   full     out  entry occupied
//   data     out  held word
//   last     out  held last flag
// -----------------------------------------------------------------------------
module hs_ser_hold_buf
  import hs_ser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             drain,
  output logic             in_ready,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic             last
);

  // Accept and drain are mutually exclusive: ready is low whenever full.
  assign in_ready = ~full & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
      last <= 1'b0;
    end else if (drain) begin
      full <= 1'b0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      data <= in_data;
      last <= in_last;
    end
  end

endmodule

// File: rtl/hs_serializer_gear.sv
// -----------------------------------------------------------------------------
// hs_serializer_gear
// HS transmit serializer: accepts WIDTH-bit words over valid/ready and emits
// them OUT_W bits per TxDDRClk cycle, LSB-first, with burst framing and
// underrun detection. Optional macro SER_SOT_SYNC_EN prefixes every burst
// with one SYNC_WORD.
// Ports:
//   TxDDRClk  in   single clock, rising edge
//   TxRst     in   synchronous active-low reset
//   s_data    in   word to serialize
//   s_valid   in   s_data valid
//   s_last    in   final word of a burst (qualified by s_valid)
//   s_ready   out  hold buffer can accept a word
//   ser_out   out  serial beat (registered)
//   ser_valid out  ser_out carries a burst beat (registered)
//   busy      out  FSM not idle or hold buffer occupied
//   underrun  out  one-cycle pulse when a burst starves before s_last
// -----------------------------------------------------------------------------
module hs_serializer_gear
  import hs_ser_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               OUT_W     = 2,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(SYNC_DEFAULT)
) (
  input  logic             TxDDRClk,
  input  logic             TxRst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [OUT_W-1:0] ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             underrun
);

  localparam int              BEATS     = calc_beats(WIDTH, OUT_W);
  localparam int              CNT_W     = calc_cnt_w(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  generate
    if ((WIDTH % OUT_W) != 0) begin : g_bad_width
      $error("hs_serializer_gear: WIDTH must be a multiple of OUT_W");
    end
    if ((WIDTH / OUT_W) < 2) begin : g_bad_beats
      $error("hs_serializer_gear: WIDTH/OUT_W must be at least 2");
    end
  endgenerate

  ser_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sh;
  logic             cur_last;

  logic             hold_full;
  logic             hold_last;
  logic [WIDTH-1:0] hold_data;

  logic             drain;
  logic             load_hold;
  logic             advance;
  logic             end_burst;
  logic             starve;
`ifdef SER_SOT_SYNC_EN
  logic             load_sync;
`endif

  hs_ser_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk     (TxDDRClk),
    .rst_n   (TxRst),
    .in_data (s_data),
    .in_valid(s_valid),
    .in_last (s_last),
    .drain   (drain),
    .in_ready(s_ready),
    .full    (hold_full),
    .data    (hold_data),
    .last    (hold_last)
  );

  assign busy = (state != ST_IDLE) | hold_full;

  always_ff @(posedge TxDDRClk) begin
    if (!TxRst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    drain      = 1'b0;
    load_hold  = 1'b0;
    advance    = 1'b0;
    end_burst  = 1'b0;
    starve     = 1'b0;
`ifdef SER_SOT_SYNC_EN
    load_sync  = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (hold_full) begin
`ifdef SER_SOT_SYNC_EN
          // Hold stays full through SYNC; it drains when data shifting begins.
          state_next = ST_SYNC;
          load_sync  = 1'b1;
`else
          state_next = ST_SHIFT;
          load_hold  = 1'b1;
          drain      = 1'b1;
`endif
        end
      end
`ifdef SER_SOT_SYNC_EN
      ST_SYNC: begin
        if (cnt == LAST_BEAT) begin
          state_next = ST_SHIFT;
          load_hold  = 1'b1;
          drain      = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
`endif
      ST_SHIFT: begin
        if (cnt == LAST_BEAT) begin
          if (cur_last) begin
            // Any word already waiting starts a new burst from IDLE.
            state_next = ST_IDLE;
            end_burst  = 1'b1;
          end else if (hold_full) begin
            load_hold = 1'b1;
            drain     = 1'b1;
          end else begin
            state_next = ST_IDLE;
            end_burst  = 1'b1;
            starve     = 1'b1;
          end
        end else begin
          advance = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ser_out is registered straight from the low slice of the word being
  // loaded; sh keeps only the beats still to be emitted.
  always_ff @(posedge TxDDRClk) begin
    if (!TxRst) begin
      cnt       <= '0;
      sh        <= '0;
      cur_last  <= 1'b0;
      ser_out   <= '0;
      ser_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= starve;
      if (load_hold) begin
        sh        <= hold_data >> OUT_W;
        ser_out   <= hold_data[OUT_W-1:0];
        cur_last  <= hold_last;
        cnt       <= '0;
        ser_valid <= 1'b1;
`ifdef SER_SOT_SYNC_EN
      end else if (load_sync) begin
        sh        <= SYNC_WORD >> OUT_W;
        ser_out   <= SYNC_WORD[OUT_W-1:0];
        cnt       <= '0;
        ser_valid <= 1'b1;
`endif
      end else if (advance) begin
        sh      <= sh >> OUT_W;
        ser_out <= sh[OUT_W-1:0];
        cnt     <= cnt + 1'b1;
      end else if (end_burst) begin
        ser_out   <= '0;
        ser_valid <= 1'b0;
        cnt       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hs_serializer_gear.sv
// -----------------------------------------------------------------------------
// tb_hs_serializer_gear
// Self-checking bench for hs_serializer_gear (8/2 main instance, 16/4 second
// instance). Expected beats are queued when words are driven and popped by a
// negedge monitor. Honours SER_SOT_SYNC_EN when defined.
// -----------------------------------------------------------------------------
module tb_hs_serializer_gear;

`ifdef SER_SOT_SYNC_EN
  localparam int SYNC_LEN = 4;
`else
  localparam int SYNC_LEN = 0;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid, s_last, s_ready;
  logic [1:0] ser_out;
  logic       ser_valid, busy, underrun;

  logic [15:0] s_data2;
  logic        s_valid2, s_last2, s_ready2;
  logic [3:0]  ser_out2;
  logic        ser_valid2, busy2, underrun2;

  hs_serializer_gear #(.WIDTH(8), .OUT_W(2)) dut (
    .TxDDRClk (clk),
    .TxRst    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .busy     (busy),
    .underrun (underrun)
  );

  hs_serializer_gear #(.WIDTH(16), .OUT_W(4)) dut16 (
    .TxDDRClk (clk),
    .TxRst    (rst_n),
    .s_data   (s_data2),
    .s_valid  (s_valid2),
    .s_last   (s_last2),
    .s_ready  (s_ready2),
    .ser_out  (ser_out2),
    .ser_valid(ser_valid2),
    .busy     (busy2),
    .underrun (underrun2)
  );

  int checks   = 0;
  int failures = 0;

  int  exp_q[$];
  bit  in_burst = 1'b0;
  bit  mon_en   = 1'b0;
  int  run_len  = 0;
  int  last_run = 0;
  int  beat_cnt = 0;
  int  und_cnt  = 0;

  typedef struct {
    logic [7:0] data;
    int         beats[4];
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_sync_if_start();
`ifdef SER_SOT_SYNC_EN
    if (!in_burst) begin
      exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(2);
    end
`endif
  endtask

  task automatic push_word(input logic [7:0] w, input logic last);
    push_sync_if_start();
    for (int k = 0; k < 4; k++) exp_q.push_back(int'((w >> (2 * k)) & 8'h03));
    in_burst = !last;
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the transfer edge.
  task automatic send(input logic [7:0] w, input logic last);
    int n;
    s_data  = w;
    s_last  = last;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("send_ready", s_ready, 1);
    if (!s_ready) begin
      s_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("s_ready_after_accept", s_ready, 0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || ser_valid || exp_q.size() != 0) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_busy"}, busy, 0);
    check({name, "_queue_left"}, exp_q.size(), 0);
    @(negedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ser_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0d required=none", ser_out);
        end else begin
          check("beat", ser_out, exp_q.pop_front());
        end
        run_len++;
        beat_cnt++;
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
        check("idle_ser_out", ser_out, 0);
      end
      if (underrun) begin
        und_cnt++;
        check("underrun_valid", ser_valid, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int got;
    int b16[8];
    int e16[8];
    int nb16;

    vecs[0].data = 8'hB4; vecs[0].beats = '{0, 1, 3, 2};
    vecs[1].data = 8'h1B; vecs[1].beats = '{3, 2, 1, 0};
    vecs[2].data = 8'hE4; vecs[2].beats = '{0, 1, 2, 3};
    vecs[3].data = 8'h00; vecs[3].beats = '{0, 0, 0, 0};
    vecs[4].data = 8'hC6; vecs[4].beats = '{2, 1, 0, 3};

    rst_n    = 1'b0;
    s_data   = '0; s_valid  = 1'b0; s_last  = 1'b0;
    s_data2  = '0; s_valid2 = 1'b0; s_last2 = 1'b0;
    s_valid  = 1'b1;   // offered during reset: must be ignored
    repeat (3) @(posedge clk);
    #1;
    check("rst_ser_out", ser_out, 0);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_s_ready16", s_ready2, 0);
    s_valid = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk); #1;
    check("post_rst_s_ready", s_ready, 1);
    check("post_rst_busy", busy, 0);
    mon_en = 1'b1;

    // Single-word bursts with hand-derived beats.
    for (int i = 0; i < 5; i++) begin
      push_sync_if_start();
      for (int k = 0; k < 4; k++) exp_q.push_back(vecs[i].beats[k]);
      in_burst = 1'b0;
      send(vecs[i].data, 1'b1);
      wait_idle("single");
      check("single_run_len", last_run, 4 + SYNC_LEN);
    end

    // Back-to-back burst, s_valid held: 12 gapless data beats.
    push_word(8'h0F, 1'b0); send(8'h0F, 1'b0);
    push_word(8'hF0, 1'b0); send(8'hF0, 1'b0);
    push_word(8'hAA, 1'b1); send(8'hAA, 1'b1);
    wait_idle("burst");
    check("burst_run_len", last_run, 12 + SYNC_LEN);

    // Starvation: no s_last and no follow-up word.
    push_word(8'h55, 1'b0);
    send(8'h55, 1'b0);
    n = 0;
    while (!underrun && n < 100) begin
      @(negedge clk); n++;
    end
    check("underrun_seen", underrun, 1);
    check("underrun_ser_valid", ser_valid, 0);
    @(negedge clk);
    check("underrun_one_cycle", underrun, 0);
    in_burst = 1'b0;
    wait_idle("underrun");
    check("underrun_run_len", last_run, 4 + SYNC_LEN);

    // Reset during beat 2 of a burst, then a fresh word.
    push_word(8'h93, 1'b1);
    base = beat_cnt;
    send(8'h93, 1'b1);
    n = 0;
    while ((beat_cnt - base) < 3 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("reset_beat2_reached", beat_cnt - base, 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    in_burst = 1'b0;
    check("midrst_ser_out", ser_out, 0);
    check("midrst_ser_valid", ser_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_underrun", underrun, 0);
    check("midrst_s_ready", s_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_word(8'h2D, 1'b1);
    send(8'h2D, 1'b1);
    wait_idle("after_rst");
    check("after_rst_run_len", last_run, 4 + SYNC_LEN);

    // 16-bit words, 4-bit beats.
`ifdef SER_SOT_SYNC_EN
    nb16 = 8;
    e16 = '{8, 11, 0, 0, 4, 3, 2, 1};
`else
    nb16 = 4;
    e16 = '{4, 3, 2, 1, 0, 0, 0, 0};
`endif
    s_data2  = 16'h1234;
    s_last2  = 1'b1;
    s_valid2 = 1'b1;
    n = 0;
    while (!s_ready2 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("w16_ready", s_ready2, 1);
    @(posedge clk); #1;
    s_valid2 = 1'b0;
    s_last2  = 1'b0;
    got = 0;
    n   = 0;
    while (got < nb16 && n < 100) begin
      @(negedge clk);
      if (ser_valid2) begin
        b16[got] = int'(ser_out2);
        got++;
      end
      n++;
    end
    check("w16_beat_count", got, nb16);
    for (int k = 0; k < nb16; k++) check("w16_beat", b16[k], e16[k]);
    @(negedge clk);
    check("w16_valid_drop", ser_valid2, 0);
    check("w16_busy", busy2, 0);
    check("w16_underrun", underrun2, 0);

    check("final_queue_empty", exp_q.size(), 0);
    check("underrun_pulses", und_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hs_serializer_gear.md
# hs_serializer_gear

Parametrised HS transmit serializer: it accepts WIDTH-bit words from the lane byte path and shifts them out OUT_W bits per TxDDRClk cycle to the DDR output stage. It adds several things to the fixed 8:2 design: a valid/ready handshake, a one-word holding buffer for gap-free bursts, burst framing with end-of-burst and underrun detection, and optional SoT sync-word insertion. All logic runs on TxDDRClk, so no TxByteClk edge detection is needed.

## Interface
- WIDTH, 8: input word width; must be a multiple of OUT_W, otherwise elaboration error
- OUT_W, 2: bits emitted per TxDDRClk cycle
- SYNC_WORD, 8'hB8 (WIDTH bits): SoT sync pattern, used only with SER_SOT_SYNC_EN
- TxDDRClk  in  1  the single clock; all state updates on rising edge
- TxRst  in  1  reset, synchronous, active-low
- s_data  in  WIDTH  word to serialize
- s_valid  in  1  s_data valid
- s_last  in  1  marks the final word of a burst; qualified by s_valid
- s_ready  out  1  buffer can accept a word
- ser_out  out  OUT_W  serial beat, registered
- ser_valid  out  1  ser_out carries a burst beat, registered
- busy  out  1  state != IDLE or hold buffer occupied
- underrun  out  1  one-cycle pulse: burst starved before s_last

## Operation
- BEATS = WIDTH/OUT_W. Beat k drives ser_out[j] = word[k*OUT_W + j], LSB first. For 8/2 this means beat0 = {d1,d0} and beat3 = {d7,d6}.
- Handshake: a transfer occurs on an edge where s_valid && s_ready.
  - s_ready = ~hold_full && TxRst; it is combinational from the registered hold flag.
  - The word and its s_last flag are written to the hold register.
- State machine, encoded in the package: IDLE, SYNC, SHIFT.
  - IDLE: ser_valid=0 and ser_out=0.
    - If hold_full, go to SYNC when SER_SOT_SYNC_EN is defined, otherwise to SHIFT.
    - On entry to SHIFT the shift register loads from the hold register, and the hold register empties.
    - On entry to SYNC the shift register loads SYNC_WORD.
  - SYNC: emit BEATS beats of SYNC_WORD. On the last beat, load the shift register from hold and go to SHIFT. Hold is always full here.
  - SHIFT: emit one beat per cycle under the beat counter (0..BEATS-1, wrapping). On the last beat (counter == BEATS-1):
    - If the current word had last=1: go to IDLE and leave the hold buffer untouched. If hold is full, the next burst starts from IDLE on the following edge.
    - Else if hold_full: load the next word with no gap and wrap the counter to 0.
    - Else: pulse underrun, go to IDLE, set ser_valid=0 on the next cycle, and abort the burst.
- Simultaneous events:
  - A hold-drain and a new accept cannot occur on the same edge, because s_ready is 0 while the hold register is full.
  - A word accepted on the same edge that the hold drains is impossible for the same reason.
- Full throughput: one word per BEATS cycles, given s_valid within BEATS-1 cycles of s_ready rising. Requires BEATS ≥ 2.
- Reset while TxRst=0, synchronous:
  - State goes to IDLE; counter, hold and shift register clear.
  - ser_out=0, ser_valid=0, busy=0, underrun=0, s_ready=0.
  - Reset mid-burst discards all in-flight data with no underrun pulse.
- Outputs are never tristated. Lane hand-off to the LP driver is the lane controller's job.

## Timing
- Latency from an accepted word on edge E0, with IDLE and no sync: shift register loads at E1, first beat is on ser_out after E1, last beat after E1+BEATS-1.
- With sync: the first data beat appears BEATS cycles later.
- ser_valid deasserts on the edge after the final beat of the s_last word.
- underrun is high for exactly one cycle, the cycle after the starved last beat. ser_valid is 0 in that same cycle.
- Reset values of all outputs are 0.

## Configuration
- SER_SOT_SYNC_EN:
  - Defined: every burst leaving IDLE is prefixed with one SYNC_WORD, serialized with the same bit order. busy and ser_valid are high during the sync beats.
  - Undefined: the SYNC state and SYNC_WORD logic are not compiled, and bursts start with data directly.

## Structure
- Package hs_ser_pkg holds:
  - the state typedef (IDLE/SYNC/SHIFT)
  - the default sync constant 8'hB8
  - a function computing BEATS and the counter width $clog2(BEATS)
- One sub-module: hs_ser_hold_buf, the one-entry data+last register with s_ready generation and a drain input.

## Test plan
- WIDTH=8, OUT_W=2, no sync: single word 8'hB4 with s_last → ser_out 0,1,3,2 on 4 consecutive cycles with ser_valid=1, then ser_valid=0 and busy=0.
- Back-to-back burst 8'h0F, 8'hF0, 8'hAA (last on the third word), s_valid held high → 12 contiguous beats 3,3,0,0,0,0,3,3,2,2,2,2 with no ser_valid gap.
- Starvation: send 8'h55 without s_last, then withhold s_valid → beats 1,1,1,1, then one-cycle underrun=1 and ser_valid=0.
- SER_SOT_SYNC_EN defined: single word 8'hFF with s_last → beats 0,2,3,2 (8'hB8), then 3,3,3,3.
- Assert TxRst=0 during beat 2 of a burst → next cycle all outputs are 0, and a fresh word serializes correctly after release.
- WIDTH=16, OUT_W=4: 16'h1234 with s_last → ser_out 4,3,2,1.
